// File: rtl/cipher_pipe.sv
// Three-stage byte cipher: Caesar shift, bit permutation and per-word XOR key,
// with the decrypt path running the inverse steps in reverse order.
module cipher_pipe #(
  parameter  int LANES = 1,
  parameter  int NKEY  = 3,
  localparam int W     = 8 * LANES,
  localparam int KAW   = (NKEY > 1) ? $clog2(NKEY) : 1
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           mode,
  input  logic [1:0]     direction,
  input  logic [4:0]     shift,
  input  logic           restart,
  input  logic           key_we,
  input  logic [KAW-1:0] key_addr,
  input  logic [7:0]     key_wdata,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   dout,
  output logic           busy
);

  localparam int STAGES = 3;
  localparam logic [KAW-1:0] LAST_IDX = KAW'(NKEY - 1);

  function automatic logic [7:0] key_init(input int i);
    case (i % 3)
      0:       return 8'h3E;
      1:       return 8'h49;
      default: return 8'h7E;
    endcase
  endfunction

  function automatic logic [4:0] mod26(input logic [4:0] s);
    return (s >= 5'd26) ? s - 5'd26 : s;
  endfunction

  // Letters rotate within their own case; every other byte value is left alone.
  function automatic logic [7:0] caesar(input logic [7:0] b, input logic [4:0] amt,
                                        input logic fwd, input logic bwd);
    logic [7:0] base;
    logic [5:0] off;
    logic       alpha;
    alpha = 1'b1;
    base  = 8'h41;
    if (b >= 8'h61 && b <= 8'h7A) base = 8'h61;
    else if (!(b >= 8'h41 && b <= 8'h5A)) alpha = 1'b0;
    off = 6'(b - base);
    if (fwd) off = off + {1'b0, amt};
    else if (bwd) off = off + (6'd26 - {1'b0, amt});
    if (off >= 6'd26) off = off - 6'd26;
    return alpha ? base + {2'b00, off} : b;
  endfunction

  function automatic logic [7:0] perm_fwd(input logic [7:0] p);
    return {p[0], p[5], p[2], p[6], p[7], p[4], p[3], p[1]};
  endfunction

  function automatic logic [7:0] perm_inv(input logic [7:0] x);
    return {x[3], x[4], x[6], x[2], x[1], x[5], x[0], x[7]};
  endfunction

  logic [7:0]     key_tab [NKEY];
  logic [KAW-1:0] kidx, kidx_nx, kidx_base;
  logic [7:0]     key_cur;
  logic           stall, en, accept;

  logic           vld_p0, vld_p1, vld_p2;
  logic [W-1:0]   data_p0, data_p1, dout_p2;
  logic           mode_p0, mode_p1;
  logic [1:0]     dir_p0, dir_p1;
  logic [4:0]     shamt_p0, shamt_p1;
  logic [7:0]     key_p0, key_p1;
  logic [W-1:0]   s1_next, s2_next;

  // The whole pipe freezes while the output word is refused downstream.
  assign stall     = vld_p2 && !out_ready;
  assign en        = !stall;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign out_valid = vld_p2;
  assign dout      = dout_p2;
  assign busy      = vld_p0 || vld_p1 || vld_p2;

  assign kidx_base = restart ? '0 : kidx;
  assign key_cur   = key_tab[kidx_base];

  always_comb begin
    kidx_nx = kidx_base;
    if (accept) kidx_nx = (kidx_base == LAST_IDX) ? '0 : kidx_base + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      for (int i = 0; i < NKEY; i++) key_tab[i] <= key_init(i);
      kidx <= '0;
    end else begin
      if (key_we && int'(key_addr) < NKEY) key_tab[key_addr] <= key_wdata;
      kidx <= kidx_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 0: capture word with its mode, direction, reduced shift and key
  always_ff @(posedge clock) begin
    if (accept) begin
      data_p0  <= din;
      mode_p0  <= mode;
      dir_p0   <= direction;
      shamt_p0 <= mod26(shift);
      key_p0   <= key_cur;
    end
  end

  always_comb begin
    s1_next = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mode_p0) s1_next[8*l +: 8] = perm_inv(data_p0[8*l +: 8] ^ key_p0);
      else         s1_next[8*l +: 8] = caesar(data_p0[8*l +: 8], shamt_p0,
                                              dir_p0 == 2'b01, dir_p0 == 2'b10);
    end
  end

  // Stage 1: first half of the transform (shift, or un-XOR and un-permute)
  always_ff @(posedge clock) begin
    if (en && vld_p0) begin
      data_p1  <= s1_next;
      mode_p1  <= mode_p0;
      dir_p1   <= dir_p0;
      shamt_p1 <= shamt_p0;
      key_p1   <= key_p0;
    end
  end

  always_comb begin
    s2_next = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mode_p1) s2_next[8*l +: 8] = caesar(data_p1[8*l +: 8], shamt_p1,
                                              dir_p1 == 2'b10, dir_p1 == 2'b01);
      else         s2_next[8*l +: 8] = perm_fwd(data_p1[8*l +: 8]) ^ key_p1;
    end
  end

  // Stage 2: output register
  always_ff @(posedge clock) begin
    if (!rst) dout_p2 <= '0;
    else if (en && vld_p1) dout_p2 <= s2_next;
  end

endmodule

// File: tb/tb_cipher_pipe.sv
// Scoreboard bench for cipher_pipe: a 4-lane and a 1-lane instance share all
// control, and an arithmetic reference model predicts every output word.
module tb_cipher_pipe;
  localparam int NKEY = 3;

  logic        clock = 1'b0;
  logic        rst, mode, restart, key_we, in_valid, out_ready;
  logic [1:0]  direction, key_addr;
  logic [4:0]  shift;
  logic [7:0]  key_wdata;
  logic [31:0] din, dout4;
  logic [7:0]  dout1;
  logic        in_ready4, out_valid4, busy4, in_ready1, out_valid1, busy1;

  always #5 clock = ~clock;

  cipher_pipe #(.LANES(4), .NKEY(NKEY)) u4 (
    .clock(clock), .rst(rst), .mode(mode), .direction(direction), .shift(shift),
    .restart(restart), .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready4), .din(din), .out_valid(out_valid4),
    .out_ready(out_ready), .dout(dout4), .busy(busy4));

  cipher_pipe #(.LANES(1), .NKEY(NKEY)) u1 (
    .clock(clock), .rst(rst), .mode(mode), .direction(direction), .shift(shift),
    .restart(restart), .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready1), .din(din[7:0]), .out_valid(out_valid1),
    .out_ready(out_ready), .dout(dout1), .busy(busy1));

  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [7:0]  mkey[NKEY];
  int          midx;
  logic        bp_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: alphabet rotation done with integer modulo arithmetic.
  function automatic logic [7:0] m_caesar(input logic [7:0] c, input int sh, input int sgn);
    int base;
    if (c >= 8'd65 && c <= 8'd90) base = 65;
    else if (c >= 8'd97 && c <= 8'd122) base = 97;
    else return c;
    return 8'(base + (((int'(c) - base + sgn * sh) % 26) + 26) % 26);
  endfunction

  function automatic logic [7:0] m_perm(input logic [7:0] p, input bit inv);
    int src[8];
    logic [7:0] r;
    src = '{1, 3, 4, 7, 6, 2, 5, 0};
    r = '0;
    for (int e = 0; e < 8; e++) begin
      if (inv) r[src[e]] = p[e];
      else     r[e] = p[src[e]];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] d, input logic md,
                                         input logic [1:0] dr, input logic [4:0] sh,
                                         input logic [7:0] k);
    logic [31:0] r;
    int sgn;
    sgn = (dr == 2'b01) ? 1 : (dr == 2'b10) ? -1 : 0;
    for (int l = 0; l < 4; l++) begin
      if (!md) r[8*l +: 8] = m_perm(m_caesar(d[8*l +: 8], int'(sh), sgn), 1'b0) ^ k;
      else     r[8*l +: 8] = m_caesar(m_perm(d[8*l +: 8] ^ k, 1'b1), int'(sh), -sgn);
    end
    return r;
  endfunction

  task automatic model_reset();
    mkey[0] = 8'h3E; mkey[1] = 8'h49; mkey[2] = 8'h7E;
    midx = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic md, input logic [1:0] dr,
                      input logic [4:0] sh, input logic rs, input logic we,
                      input logic [1:0] ka, input logic [7:0] kd,
                      input logic ovr, input logic [31:0] oexp);
    int n = 0;
    logic [7:0] k;
    din = d; mode = md; direction = dr; shift = sh; restart = rs;
    key_we = we; key_addr = ka; key_wdata = kd; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready4 && n < 50) begin @(negedge clock); n++; end
    if (!in_ready4) begin
      check("accept_timeout", 32'(in_ready4), 32'd1);
    end else begin
      k = rs ? mkey[0] : mkey[midx];
      exp_q.push_back(ovr ? oexp : m_word(d, md, dr, sh, k));
      midx = rs ? (1 % NKEY) : (midx + 1) % NKEY;
      if (we && int'(ka) < NKEY) mkey[ka] = kd;
    end
    @(posedge clock); #1;
    in_valid = 1'b0; restart = 1'b0; key_we = 1'b0;
  endtask

  task automatic sendm(input logic [31:0] d, input logic md, input logic [1:0] dr,
                       input logic [4:0] sh, input logic rs);
    send(d, md, dr, sh, rs, 1'b0, 2'd0, 8'd0, 1'b0, 32'd0);
  endtask

  task automatic sendc(input logic [31:0] d, input logic md, input logic [1:0] dr,
                       input logic [4:0] sh, input logic rs, input logic [31:0] e);
    send(d, md, dr, sh, rs, 1'b0, 2'd0, 8'd0, 1'b1, e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy4) && n < 100) begin @(negedge clock); n++; end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid4), 32'd0);
    check({tag, "_busy"},      32'(busy4),      32'd0);
    check({tag, "_dout"},      dout4,           32'd0);
    check({tag, "_dout1"},     32'(dout1),      32'd0);
    check({tag, "_in_ready"},  32'(in_ready4),  32'd1);
  endtask

  always @(negedge clock) begin
    if (rst && out_valid4 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid4), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("dout_lanes4", dout4, e);
        check("dout_lanes1", 32'(dout1), 32'(e[7:0]));
        check("out_valid_lanes1", 32'(out_valid1), 32'd1);
        got_q.push_back(dout4);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] g[$];
    logic [31:0] rd[16];
    logic [1:0]  rdir[16];
    logic [4:0]  rsh[16];

    rst = 1'b0; mode = 1'b0; restart = 1'b0; key_we = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; direction = 2'b00; key_addr = 2'd0; key_wdata = 8'd0;
    shift = 5'd0; din = 32'd0; bp_on = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    @(posedge clock); #1 rst = 1'b1;

    // Known-answer word and three-cycle latency
    sendc(32'h41414141, 1'b0, 2'b00, 5'd0, 1'b1, 32'hAEAEAEAE);
    @(negedge clock); check("latency_t1", 32'(out_valid4), 32'd0);
    @(negedge clock); check("latency_t2", 32'(out_valid4), 32'd0);
    @(negedge clock); check("latency_t3", 32'(out_valid4), 32'd1);
    drain();
    sendc(32'hAEAEAEAE, 1'b1, 2'b00, 5'd0, 1'b1, 32'h41414141);
    drain();

    // Shift modulo 26 and non-letter pass-through
    got_q.delete();
    sendm(32'h5A5A5A5A, 1'b0, 2'b01, 5'd3,  1'b1);
    sendm(32'h5A5A5A5A, 1'b0, 2'b01, 5'd29, 1'b1);
    sendm(32'h31313131, 1'b0, 2'b01, 5'd3,  1'b1);
    drain();
    g = got_q;
    check("shift_results", 32'(g.size()), 32'd3);
    if (g.size() == 3) begin
      check("shift3_eq_shift29", g[1], g[0]);
      sendc(g[0], 1'b1, 2'b00, 5'd0, 1'b1, 32'h43434343);
      sendc(g[1], 1'b1, 2'b00, 5'd0, 1'b1, 32'h43434343);
      sendc(g[2], 1'b1, 2'b00, 5'd0, 1'b1, 32'h31313131);
      drain();
    end

    // Key schedule rotation and restart
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h3E3E3E3E);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h49494949);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h7E7E7E7E);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h3E3E3E3E);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h49494949);
    restart = 1'b1; @(posedge clock); #1 restart = 1'b0; midx = 0;
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h3E3E3E3E);
    drain();

    // Back-pressure with a full pipe
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          sendm($urandom, 1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'b0);
      end
      begin
        int n = 0;
        logic [31:0] hold;
        @(negedge clock);
        while (!out_valid4 && n < 20) begin @(negedge clock); n++; end
        hold = dout4;
        repeat (5) begin
          @(negedge clock);
          check("stall_in_ready", 32'(in_ready4), 32'd0);
          check("stall_out_valid", 32'(out_valid4), 32'd1);
          check("stall_dout", dout4, hold);
          check("stall_busy", 32'(busy4), 32'd1);
        end
        @(posedge clock); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Key write colliding with a word that reads the same entry
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h3E3E3E3E);
    send(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 32'h49494949);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h7E7E7E7E);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h3E3E3E3E);
    send(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b1, 2'd3, 8'hFF, 1'b1, 32'h00000000);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h7E7E7E7E);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h3E3E3E3E);
    drain();

    // Random encrypt/decrypt round trip under random back-pressure
    got_q.delete();
    bp_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          rd[i] = $urandom; rdir[i] = 2'($urandom_range(0, 3)); rsh[i] = 5'($urandom_range(0, 31));
          sendm(rd[i], 1'b0, rdir[i], rsh[i], i == 0);
          if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
        end
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin @(posedge clock); #1 out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    drain();
    g = got_q;
    check("roundtrip_results", 32'(g.size()), 32'd16);
    if (g.size() == 16) begin
      for (int i = 0; i < 16; i++) sendc(g[i], 1'b1, rdir[i], rsh[i], i == 0, rd[i]);
      drain();
    end

    // Reset with words in flight
    sendc(32'h11111111, 1'b0, 2'b00, 5'd0, 1'b0, 32'h0);
    sendc(32'h22222222, 1'b0, 2'b00, 5'd0, 1'b0, 32'h0);
    sendc(32'h33333333, 1'b0, 2'b00, 5'd0, 1'b0, 32'h0);
    rst = 1'b0;
    @(posedge clock); #1 rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clock);
    check_idle("midreset");
    @(posedge clock); #1;
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h3E3E3E3E);
    sendc(32'h0, 1'b0, 2'b00, 5'd0, 1'b0, 32'h49494949);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
